// File: rtl/imem_load_responder.sv
// imem_load_responder: instruction memory for the single-cycle 8-bit core.
// A byte-stream loader (valid/ready) fills the memory while the core is held
// in reset; cpu_run releases the core once a complete image is present.
// Fetches are answered combinationally so the core sees zero read latency.
// Optional feature macro: IMEM_CHECKSUM_EN -- the load_last byte is an XOR
// checksum of the image rather than program data; adds the chk_err port.
module imem_load_responder #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 8,
  parameter logic [DATA_W-1:0] NOP = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_load,
  input  logic              start_run,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_run,
  output logic [ADDR_W:0]   load_count,
`ifdef IMEM_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic                load_ready_reg;
  logic                cpu_run_reg;
  logic [ADDR_W:0]     load_count_reg;
  logic                overflow_reg;
`ifdef IMEM_CHECKSUM_EN
  logic                chk_err_reg;
  logic [DATA_W-1:0]   csum_reg;
`endif

  // Program storage; deliberately has no reset so an image survives reset.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic xfer;
  logic wr_en;
  logic at_end;

  assign xfer   = (state_reg == ST_LOAD) && load_valid && load_ready_reg;
  assign at_end = (wr_ptr_reg == {ADDR_W{1'b1}});
`ifdef IMEM_CHECKSUM_EN
  // The checksum byte itself is never stored.
  assign wr_en  = xfer && reset && !load_last;
`else
  assign wr_en  = xfer && reset;
`endif

  // Memory write port: only active on accepted loader handshakes.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= load_data;
    end
  end

  // Load/run sequencing with all status outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      load_ready_reg <= 1'b0;
      cpu_run_reg    <= 1'b0;
      load_count_reg <= '0;
      overflow_reg   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      chk_err_reg    <= 1'b0;
      csum_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_load) begin
            state_reg      <= ST_LOAD;
            wr_ptr_reg     <= '0;
            load_count_reg <= '0;
            overflow_reg   <= 1'b0;
            load_ready_reg <= 1'b1;
`ifdef IMEM_CHECKSUM_EN
            chk_err_reg    <= 1'b0;
            csum_reg       <= '0;
`endif
          end else if (start_run) begin
            state_reg   <= ST_RUN;
            cpu_run_reg <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (xfer) begin
`ifdef IMEM_CHECKSUM_EN
            if (load_last) begin
              load_ready_reg <= 1'b0;
              if (load_data == csum_reg) begin
                state_reg   <= ST_RUN;
                cpu_run_reg <= 1'b1;
              end else begin
                state_reg   <= ST_IDLE;
                chk_err_reg <= 1'b1;
              end
            end else begin
              wr_ptr_reg     <= wr_ptr_reg + 1'b1;
              load_count_reg <= load_count_reg + 1'b1;
              csum_reg       <= csum_reg ^ load_data;
              if (at_end) begin
                state_reg      <= ST_IDLE;
                overflow_reg   <= 1'b1;
                load_ready_reg <= 1'b0;
              end
            end
`else
            wr_ptr_reg     <= wr_ptr_reg + 1'b1;
            load_count_reg <= load_count_reg + 1'b1;
            if (load_last) begin
              state_reg      <= ST_RUN;
              cpu_run_reg    <= 1'b1;
              load_ready_reg <= 1'b0;
            end else if (at_end) begin
              state_reg      <= ST_IDLE;
              overflow_reg   <= 1'b1;
              load_ready_reg <= 1'b0;
            end
`endif
          end
        end

        ST_RUN: begin
          if (start_load) begin
            state_reg      <= ST_LOAD;
            cpu_run_reg    <= 1'b0;
            load_ready_reg <= 1'b1;
            wr_ptr_reg     <= '0;
            load_count_reg <= '0;
            overflow_reg   <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            chk_err_reg    <= 1'b0;
            csum_reg       <= '0;
`endif
          end
        end

        default: begin
          state_reg      <= ST_IDLE;
          load_ready_reg <= 1'b0;
          cpu_run_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency fetch; the core only sees program bytes while running.
  always_comb begin
    fetch_data = NOP;
    if (state_reg == ST_RUN) begin
      fetch_data = mem[fetch_addr];
    end
  end

  assign load_ready = load_ready_reg;
  assign cpu_run    = cpu_run_reg;
  assign load_count = load_count_reg;
  assign overflow   = overflow_reg;
`ifdef IMEM_CHECKSUM_EN
  assign chk_err    = chk_err_reg;
`endif

endmodule
